// File: rtl/array_seq_ctrl.sv
// Pass sequencer for the systolic MAC-tile array: drives mode/inst_w/accum_limit
// and the FIFO strobes for one weight-stationary or output-stationary pass per start.
module array_seq_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_in,
  input  logic [cnt_bw-1:0] len,
  output logic              mode,
  output logic [1:0]        inst_w,
  output logic [3:0]        accum_limit,
  output logic              l0_rd,
  output logic              w_rd,
  output logic              ofifo_wr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KLOAD    = 3'd1;
  localparam logic [2:0] S_KWAIT    = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_OS_RUN   = 3'd5;
  localparam logic [2:0] S_OS_DRAIN = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  localparam logic [cnt_bw-1:0] ROW_LAST   = cnt_bw'(row - 1);
  localparam logic [cnt_bw-1:0] COL_LAST   = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] DRAIN_LAST = cnt_bw'(row + col - 2);
  localparam logic [cnt_bw-1:0] OS_LEN_MAX = cnt_bw'(16);
  localparam logic [cnt_bw-1:0] CNT_ONE    = cnt_bw'(1);

  // Offset counter spans EXEC plus DRAIN, so it needs headroom beyond len.
  localparam int OFF_W = cnt_bw + 1 + $clog2(row + col + 1);
  localparam logic [OFF_W-1:0] ROW_OFF = OFF_W'(row);

  logic [2:0]        state_reg, state_next;
  logic [cnt_bw-1:0] cnt_reg, cnt_next;
  logic [cnt_bw-1:0] len_reg, len_next;
  logic [OFF_W-1:0]  off_reg, off_next;
  logic              mode_reg, mode_next;
  logic [3:0]        acc_reg, acc_next;
  logic [1:0]        inst_w_reg, inst_w_next;
  logic              l0_rd_reg, l0_rd_next;
  logic              w_rd_reg, w_rd_next;
  logic              ofifo_wr_reg, ofifo_wr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              wsout_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_ONE;
    len_next   = len_reg;
    mode_next  = mode_reg;
    acc_next   = acc_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (start) begin
          if (len == '0 || (mode_in && len > OS_LEN_MAX)) begin
            err_next = 1'b1;
          end else begin
            mode_next = mode_in;
            len_next  = len;
            if (mode_in) begin
              acc_next   = len[3:0] - 4'd1;
              state_next = S_OS_RUN;
            end else begin
              state_next = S_KLOAD;
            end
          end
        end
      end
      S_KLOAD: if (cnt_reg == ROW_LAST) begin
        state_next = S_KWAIT;
        cnt_next   = '0;
      end
      S_KWAIT: if (cnt_reg == COL_LAST) begin
        state_next = S_EXEC;
        cnt_next   = '0;
      end
      S_EXEC: if (cnt_reg == len_reg - CNT_ONE) begin
        state_next = S_DRAIN;
        cnt_next   = '0;
      end
      S_DRAIN, S_OS_DRAIN: if (cnt_reg == DRAIN_LAST) begin
        state_next = S_FIN;
        cnt_next   = '0;
      end
      S_OS_RUN: if (cnt_reg == len_reg - CNT_ONE) begin
        state_next = S_OS_DRAIN;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    wsout_next = (state_next == S_EXEC) || (state_next == S_DRAIN);
    off_next   = '0;
    if (wsout_next && ((state_reg == S_EXEC) || (state_reg == S_DRAIN)))
      off_next = off_reg + OFF_W'(1);
    ofifo_wr_next = wsout_next && (off_next >= ROW_OFF) &&
                    (off_next < ROW_OFF + OFF_W'(len_reg));
    inst_w_next = 2'b00;
    if (state_next == S_KLOAD)
      inst_w_next = 2'b01;
    else if (state_next == S_EXEC || state_next == S_OS_RUN)
      inst_w_next = 2'b10;
    l0_rd_next = (state_next == S_KLOAD) || (state_next == S_EXEC) ||
                 (state_next == S_OS_RUN);
    w_rd_next  = (state_next == S_OS_RUN);
    busy_next  = (state_next != S_IDLE);
    done_next  = (state_next == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      len_reg      <= '0;
      off_reg      <= '0;
      mode_reg     <= 1'b0;
      acc_reg      <= 4'd0;
      inst_w_reg   <= 2'b00;
      l0_rd_reg    <= 1'b0;
      w_rd_reg     <= 1'b0;
      ofifo_wr_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      off_reg      <= off_next;
      mode_reg     <= mode_next;
      acc_reg      <= acc_next;
      inst_w_reg   <= inst_w_next;
      l0_rd_reg    <= l0_rd_next;
      w_rd_reg     <= w_rd_next;
      ofifo_wr_reg <= ofifo_wr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign mode        = mode_reg;
  assign inst_w      = inst_w_reg;
  assign accum_limit = acc_reg;
  assign l0_rd       = l0_rd_reg;
  assign w_rd        = w_rd_reg;
  assign ofifo_wr    = ofifo_wr_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Bench for array_seq_ctrl: pass-timeline model checked every cycle plus
// literal expectations taken from hand-worked timelines.
module tb_array_seq_ctrl;

  localparam int R = 8;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       reset, start, mode_in;
  logic [7:0] len;
  logic       mode, l0_rd, w_rd, ofifo_wr, busy, done, err;
  logic [1:0] inst_w;
  logic [3:0] accum_limit;

  array_seq_ctrl #(.row(R), .col(C), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_in(mode_in), .len(len),
    .mode(mode), .inst_w(inst_w), .accum_limit(accum_limit), .l0_rd(l0_rd),
    .w_rd(w_rd), .ofifo_wr(ofifo_wr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Model: m_t is the cycle index within the current pass (0 = idle).
  int         m_t = 0, m_total = 0, m_len = 0;
  logic       m_mode = 1'b0, m_err = 1'b0;
  logic [3:0] m_acc = 4'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_t <= 0; m_total <= 0; m_len <= 0;
      m_mode <= 1'b0; m_err <= 1'b0; m_acc <= 4'd0;
    end else begin
      m_err <= 1'b0;
      if (m_t == 0) begin
        if (start) begin
          if (len == 0 || (mode_in && len > 16)) begin
            m_err <= 1'b1;
          end else begin
            m_mode  <= mode_in;
            m_len   <= int'(len);
            m_t     <= 1;
            m_total <= mode_in ? int'(len) + R + C : 2*R + 2*C + int'(len);
            if (mode_in) m_acc <= 4'(int'(len) - 1);
          end
        end
      end else if (m_t == m_total) begin
        m_t <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic int  t     = m_t;
      automatic bit  kload = !m_mode && t >= 1 && t <= R;
      automatic bit  exec  = m_mode ? (t >= 1 && t <= m_len)
                                    : (t > R + C && t <= R + C + m_len);
      automatic bit  ofw   = !m_mode && t >= 2*R + C + 1 && t <= 2*R + C + m_len;
      chk("m_inst_w", int'(inst_w), int'({exec, kload}));
      chk("m_l0_rd", int'(l0_rd), int'(kload | exec));
      chk("m_w_rd", int'(w_rd), int'(m_mode & exec));
      chk("m_ofifo_wr", int'(ofifo_wr), int'(ofw));
      chk("m_busy", int'(busy), int'(t != 0));
      chk("m_done", int'(done), int'(t != 0 && t == m_total));
      chk("m_err", int'(err), int'(m_err));
      chk("m_mode", int'(mode), int'(m_mode));
      chk("m_accum", int'(accum_limit), int'(m_acc));
    end
  end

  task automatic start_cmd(input logic m, input int l);
    start = 1'b1; mode_in = m; len = 8'(l);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Literal points of the WS len=5 timeline.
  task automatic ws5_checks(input string tag);
    case (cyc)
      1:  chk({tag, "_inst1"}, int'(inst_w), 1);
      8:  chk({tag, "_inst8"}, int'(inst_w), 1);
      9:  chk({tag, "_inst9"}, int'(inst_w), 0);
      16: chk({tag, "_l0_16"}, int'(l0_rd), 0);
      17: begin chk({tag, "_inst17"}, int'(inst_w), 2); chk({tag, "_l0_17"}, int'(l0_rd), 1); end
      21: chk({tag, "_inst21"}, int'(inst_w), 2);
      22: chk({tag, "_inst22"}, int'(inst_w), 0);
      24: chk({tag, "_of24"}, int'(ofifo_wr), 0);
      25: chk({tag, "_of25"}, int'(ofifo_wr), 1);
      29: chk({tag, "_of29"}, int'(ofifo_wr), 1);
      30: chk({tag, "_of30"}, int'(ofifo_wr), 0);
      36: chk({tag, "_done36"}, int'(done), 0);
      37: begin chk({tag, "_done37"}, int'(done), 1); chk({tag, "_busy37"}, int'(busy), 1); end
      38: chk({tag, "_busy38"}, int'(busy), 0);
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode_in = 1'b0; len = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_inst", int'(inst_w), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_acc", int'(accum_limit), 0);
    chk("rst_strobes", int'({l0_rd, w_rd, ofifo_wr, done, err}), 0);
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);

    start_cmd(1'b0, 5);
    repeat (40) begin step(); ws5_checks("ws5"); end
    $display("[TB] txn ws len=5");

    start_cmd(1'b1, 4);
    repeat (60) begin
      step();
      if (cyc == 1) begin chk("os4_mode", int'(mode), 1); chk("os4_acc", int'(accum_limit), 3); end
      if (cyc == 4) chk("os4_rd4", int'({inst_w, l0_rd, w_rd}), 11);
      if (cyc == 5) chk("os4_inst5", int'(inst_w), 0);
      if (cyc == 19) begin chk("os4_done19", int'(done), 0); start = 1'b1; mode_in = 1'b0; len = 8'd2; end
      if (cyc == 20) chk("os4_done20", int'(done), 1);
      if (cyc == 21) begin chk("b2b_busy21", int'(busy), 0); chk("os4_mode_hold", int'(mode), 1); end
      if (cyc == 22) begin chk("b2b_busy22", int'(busy), 1); chk("b2b_inst22", int'(inst_w), 1); start = 1'b0; end
    end
    $display("[TB] txn os len=4 then back-to-back ws len=2");

    start_cmd(1'b0, 0);
    step(); chk("rej0_err", int'(err), 1); chk("rej0_busy", int'(busy), 0);
    step(); chk("rej0_err2", int'(err), 0);
    $display("[TB] txn ws len=0 rejected");

    start_cmd(1'b1, 17);
    step(); chk("rej17_err", int'(err), 1); chk("rej17_busy", int'(busy), 0);
    step();
    $display("[TB] txn os len=17 rejected");

    start_cmd(1'b1, 16);
    repeat (34) begin
      step();
      if (cyc == 1) begin chk("os16_acc", int'(accum_limit), 15); chk("os16_err", int'(err), 0); end
      if (cyc == 16) chk("os16_inst16", int'(inst_w), 2);
      if (cyc == 17) chk("os16_inst17", int'(inst_w), 0);
      if (cyc == 32) chk("os16_done", int'(done), 1);
    end
    $display("[TB] txn os len=16");

    start_cmd(1'b0, 1);
    repeat (36) begin
      step();
      if (cyc >= 16 && cyc <= 18) chk("ws1_inst", int'(inst_w), cyc == 17 ? 2 : 0);
      if (cyc >= 24 && cyc <= 26) chk("ws1_of", int'(ofifo_wr), cyc == 25 ? 1 : 0);
      if (cyc == 33) chk("ws1_done", int'(done), 1);
      if (cyc == 15) chk("ws1_acc_kept", int'(accum_limit), 15);
    end
    $display("[TB] txn ws len=1");

    start_cmd(1'b0, 5);
    repeat (40) begin
      step();
      if (cyc == 10) begin start = 1'b1; mode_in = 1'b1; len = 8'd3; end
      if (cyc == 11) start = 1'b0;
      ws5_checks("wsign");
    end
    $display("[TB] txn ws len=5 with ignored start");

    start_cmd(1'b0, 5);
    repeat (30) begin
      step();
      if (cyc == 18) reset = 1'b1;
      if (cyc == 19) begin
        reset = 1'b0;
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_inst", int'(inst_w), 0);
        chk("rmid_acc", int'(accum_limit), 0);
        chk("rmid_strobes", int'({mode, l0_rd, w_rd, ofifo_wr, done, err}), 0);
      end
      if (cyc > 19) chk("rmid_nodone", int'(done), 0);
    end
    $display("[TB] txn ws len=5 aborted by reset");

    start_cmd(1'b1, 3);
    repeat (22) begin
      step();
      if (cyc == 1) chk("os3_acc", int'(accum_limit), 2);
      if (cyc == 19) chk("os3_done", int'(done), 1);
      if (cyc == 20) chk("os3_idle", int'(busy), 0);
    end
    $display("[TB] txn os len=3 after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
